multu_hilo_unit: RTL and testbench



---
 rtl/multu_hilo_unit.sv | 121 ++++++++++++
 tb/tb_multu_hilo_unit.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/multu_hilo_unit.sv
// Multicycle unsigned shift-add multiplier with a HI/LO register pair.
// One iteration per MULTU edge; the product is committed to HI/LO by the HILO_WR strobe.
module multu_hilo_unit #(
   parameter int          WIDTH   = 32,
   parameter logic [5:0]  MULTU   = 6'b011001,
   parameter logic [5:0]  MFHI    = 6'b010000,
   parameter logic [5:0]  MFLO    = 6'b010010,
   parameter logic [5:0]  HILO_WR = 6'b111111
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [5:0]       Signal,
   input  logic [WIDTH-1:0] dataA,
   input  logic [WIDTH-1:0] dataB,
   output logic [WIDTH-1:0] dataOut,
   output logic             busy,
   output logic             done
);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t             r_state, w_state_next;
   logic [2*WIDTH-1:0] r_mcand, w_mcand_next;
   logic [WIDTH-1:0]   r_mplier, w_mplier_next;
   logic [2*WIDTH-1:0] r_product, w_product_next;
   logic [5:0]         r_count, w_count_next;
   logic [WIDTH-1:0]   r_hi, w_hi_next;
   logic [WIDTH-1:0]   r_lo, w_lo_next;
   logic [WIDTH-1:0]   r_data_out;
   logic               r_busy, r_done;
   logic [2*WIDTH-1:0] w_load_mcand;

   assign w_load_mcand = {{WIDTH{1'b0}}, dataA};

   always_comb begin
      w_state_next   = r_state;
      w_mcand_next   = r_mcand;
      w_mplier_next  = r_mplier;
      w_product_next = r_product;
      w_count_next   = r_count;
      w_hi_next      = r_hi;
      w_lo_next      = r_lo;
      case (r_state)
         IDLE: begin
            if (Signal == MULTU) begin
               // Load and run iteration 0 on the loaded operands in the same edge.
               w_mcand_next   = w_load_mcand << 1;
               w_mplier_next  = dataB >> 1;
               w_product_next = dataB[0] ? w_load_mcand : '0;
               w_count_next   = 6'd1;
               w_state_next   = RUN;
            end
         end
         RUN: begin
            if (Signal == MULTU) begin
               w_product_next = r_mplier[0] ? (r_product + r_mcand) : r_product;
               w_mcand_next   = r_mcand << 1;
               w_mplier_next  = r_mplier >> 1;
               w_count_next   = r_count + 6'd1;
               if (r_count == 6'(WIDTH - 1))
                  w_state_next = DONE;
            end else begin
               w_product_next = '0;
               w_count_next   = '0;
               w_state_next   = IDLE;
            end
         end
         DONE: begin
            if (Signal == HILO_WR) begin
               w_hi_next      = r_product[2*WIDTH-1:WIDTH];
               w_lo_next      = r_product[WIDTH-1:0];
               w_product_next = '0;
               w_count_next   = '0;
               w_state_next   = IDLE;
            end else if (Signal != MULTU) begin
               w_product_next = '0;
               w_count_next   = '0;
               w_state_next   = IDLE;
            end
         end
         default: begin
            w_state_next = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state    <= IDLE;
         r_mcand    <= '0;
         r_mplier   <= '0;
         r_product  <= '0;
         r_count    <= '0;
         r_hi       <= '0;
         r_lo       <= '0;
         r_data_out <= '0;
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
      end else begin
         r_state   <= w_state_next;
         r_mcand   <= w_mcand_next;
         r_mplier  <= w_mplier_next;
         r_product <= w_product_next;
         r_count   <= w_count_next;
         r_hi      <= w_hi_next;
         r_lo      <= w_lo_next;
         r_busy    <= (w_state_next == RUN);
         r_done    <= (w_state_next == DONE);
         // Reads see HI/LO as they were before this edge.
         if (Signal == MFHI)
            r_data_out <= r_hi;
         else if (Signal == MFLO)
            r_data_out <= r_lo;
      end
   end

   assign dataOut = r_data_out;
   assign busy    = r_busy;
   assign done    = r_done;

endmodule

// File: tb/tb_multu_hilo_unit.sv
// Directed bench for multu_hilo_unit: multiply, commit, read back, abort and reset cases.
module tb_multu_hilo_unit;

   localparam logic [5:0] C_MULTU   = 6'b011001;
   localparam logic [5:0] C_MFHI    = 6'b010000;
   localparam logic [5:0] C_MFLO    = 6'b010010;
   localparam logic [5:0] C_HILO_WR = 6'b111111;
   localparam logic [5:0] C_ADD     = 6'b100000;
   localparam logic [5:0] C_NOP     = 6'b000000;

   logic        clk = 1'b0;
   logic        reset;
   logic [5:0]  Signal;
   logic [31:0] dataA, dataB;
   logic [31:0] dataOut;
   logic        busy, done;

   int total = 0;
   int bad   = 0;

   multu_hilo_unit dut (
      .clk    (clk),
      .reset  (reset),
      .Signal (Signal),
      .dataA  (dataA),
      .dataB  (dataB),
      .dataOut(dataOut),
      .busy   (busy),
      .done   (done)
   );

   always #5 clk = ~clk;

   task automatic step(input logic [5:0] sig);
      Signal = sig;
      @(posedge clk);
      #1;
   endtask

   task automatic multu_edges(input logic [31:0] a, input logic [31:0] b, input int n);
      dataA = a;
      dataB = b;
      for (int i = 0; i < n; i++) step(C_MULTU);
   endtask

   task automatic test_reset;
      reset = 1'b1;
      step(C_NOP);
      step(C_NOP);
      reset = 1'b0;
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%0b want=0", busy); end
      total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done got=%0b want=0", done); end
      total++; if (dataOut !== 32'h0) begin bad++; $display("FAIL reset_dataout got=%h want=00000000", dataOut); end
      $display("txn reset: busy=%0b done=%0b dataOut=%h", busy, done, dataOut);
   endtask

   task automatic test_basic;
      dataA = 32'd3;
      dataB = 32'd5;
      for (int i = 0; i < 31; i++) begin
         step(C_MULTU);
         if (i == 0 || i == 30) begin
            total++; if (busy !== 1'b1 || done !== 1'b0) begin
               bad++; $display("FAIL basic_run_edge%0d busy=%0b done=%0b want busy=1 done=0", i + 1, busy, done);
            end
         end
         dataA = 32'hDEAD_BEEF;  // operands must not be re-sampled in RUN
         dataB = 32'h1234_5678;
      end
      step(C_MULTU);
      total++; if (done !== 1'b1 || busy !== 1'b0) begin
         bad++; $display("FAIL basic_done_edge32 busy=%0b done=%0b want busy=0 done=1", busy, done);
      end
      step(C_HILO_WR);
      total++; if (done !== 1'b0) begin bad++; $display("FAIL basic_commit_done got=%0b want=0", done); end
      step(C_MFLO);
      total++; if (dataOut !== 32'h0000_000F) begin bad++; $display("FAIL basic_mflo got=%h want=0000000f", dataOut); end
      step(C_MFHI);
      total++; if (dataOut !== 32'h0) begin bad++; $display("FAIL basic_mfhi got=%h want=00000000", dataOut); end
      $display("txn basic 3*5: done after 32 edges, LO=0000000f HI=00000000 last dataOut=%h", dataOut);
   endtask

   task automatic test_max;
      multu_edges(32'hFFFF_FFFF, 32'hFFFF_FFFF, 32);
      step(C_HILO_WR);
      step(C_MFHI);
      total++; if (dataOut !== 32'hFFFF_FFFE) begin bad++; $display("FAIL max_mfhi got=%h want=fffffffe", dataOut); end
      step(C_MFLO);
      total++; if (dataOut !== 32'h0000_0001) begin bad++; $display("FAIL max_mflo got=%h want=00000001", dataOut); end
      $display("txn max ffffffff^2: dataOut=%h", dataOut);
   endtask

   task automatic test_abort;
      multu_edges(32'd7, 32'd6, 32);
      step(C_HILO_WR);
      multu_edges(32'd100, 32'd100, 10);
      total++; if (busy !== 1'b1) begin bad++; $display("FAIL abort_busy_before got=%0b want=1", busy); end
      step(C_ADD);
      total++; if (busy !== 1'b0 || done !== 1'b0) begin
         bad++; $display("FAIL abort_idle busy=%0b done=%0b want 0 0", busy, done);
      end
      step(C_MFLO);
      total++; if (dataOut !== 32'd42) begin bad++; $display("FAIL abort_mflo got=%0d want=42", dataOut); end
      step(C_HILO_WR);
      step(C_MFHI);
      total++; if (dataOut !== 32'd0) begin bad++; $display("FAIL abort_idle_wr_mfhi got=%h want=00000000", dataOut); end
      step(C_MFLO);
      total++; if (dataOut !== 32'd42) begin bad++; $display("FAIL abort_idle_wr_mflo got=%0d want=42", dataOut); end
      $display("txn abort: LO stays %0d", dataOut);
   endtask

   task automatic test_reset_mid_run;
      multu_edges(32'd11, 32'd13, 19);
      reset = 1'b1;
      step(C_MULTU);
      reset = 1'b0;
      total++; if (busy !== 1'b0 || done !== 1'b0) begin
         bad++; $display("FAIL rstmid_flags busy=%0b done=%0b want 0 0", busy, done);
      end
      total++; if (dataOut !== 32'h0) begin bad++; $display("FAIL rstmid_dataout got=%h want=00000000", dataOut); end
      step(C_MFLO);
      total++; if (dataOut !== 32'h0) begin bad++; $display("FAIL rstmid_mflo got=%h want=00000000", dataOut); end
      $display("txn reset mid-run: busy=%0b done=%0b LO=%h", busy, done, dataOut);
   endtask

   task automatic test_reset_on_commit;
      multu_edges(32'd9, 32'd9, 32);
      reset = 1'b1;
      step(C_HILO_WR);
      reset = 1'b0;
      step(C_MFLO);
      total++; if (dataOut !== 32'h0) begin bad++; $display("FAIL rstwr_mflo got=%h want=00000000", dataOut); end
      step(C_MFHI);
      total++; if (dataOut !== 32'h0) begin bad++; $display("FAIL rstwr_mfhi got=%h want=00000000", dataOut); end
      $display("txn reset on commit edge: HI=LO=0 dataOut=%h", dataOut);
   endtask

   task automatic test_hold_done;
      multu_edges(32'd5, 32'd7, 32);
      multu_edges(32'd1000, 32'd3, 5);
      total++; if (done !== 1'b1 || busy !== 1'b0) begin
         bad++; $display("FAIL hold_done busy=%0b done=%0b want busy=0 done=1", busy, done);
      end
      step(C_HILO_WR);
      step(C_MFLO);
      total++; if (dataOut !== 32'd35) begin bad++; $display("FAIL hold_mflo got=%0d want=35", dataOut); end
      $display("txn hold in DONE: LO=%0d", dataOut);
   endtask

   task automatic test_carry;
      multu_edges(32'h0001_0000, 32'h0001_0000, 32);
      step(C_HILO_WR);
      step(C_MFHI);
      total++; if (dataOut !== 32'h0000_0001) begin bad++; $display("FAIL carry_mfhi got=%h want=00000001", dataOut); end
      step(C_MFLO);
      total++; if (dataOut !== 32'h0) begin bad++; $display("FAIL carry_mflo got=%h want=00000000", dataOut); end
      $display("txn carry 10000*10000: LO=%h", dataOut);
   endtask

   task automatic test_zero_operand;
      multu_edges(32'd0, 32'd12345, 31);
      total++; if (done !== 1'b0 || busy !== 1'b1) begin
         bad++; $display("FAIL zero_no_early_exit busy=%0b done=%0b want busy=1 done=0", busy, done);
      end
      step(C_MULTU);
      total++; if (done !== 1'b1) begin bad++; $display("FAIL zero_done got=%0b want=1", done); end
      step(C_HILO_WR);
      step(C_MFLO);
      total++; if (dataOut !== 32'h0) begin bad++; $display("FAIL zero_mflo got=%h want=00000000", dataOut); end
      $display("txn zero operand: LO=%h", dataOut);
   endtask

   task automatic test_back_to_back;
      multu_edges(32'd2, 32'd3, 32);
      step(C_HILO_WR);
      multu_edges(32'd4, 32'd5, 1);
      total++; if (busy !== 1'b1) begin bad++; $display("FAIL b2b_restart_busy got=%0b want=1", busy); end
      multu_edges(32'd4, 32'd5, 31);
      step(C_HILO_WR);
      step(C_MFLO);
      total++; if (dataOut !== 32'd20) begin bad++; $display("FAIL b2b_mflo got=%0d want=20", dataOut); end
      $display("txn back-to-back 2*3 then 4*5: LO=%0d", dataOut);
   endtask

   initial begin
      reset  = 1'b0;
      Signal = C_NOP;
      dataA  = '0;
      dataB  = '0;
      test_reset();
      test_basic();
      test_max();
      test_abort();
      test_reset_mid_run();
      test_reset_on_commit();
      test_hold_done();
      test_carry();
      test_zero_operand();
      test_back_to_back();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
